// File: rtl/hs32_mem_arbiter_if.sv
// hs32_mem_arbiter_if: fetch, execute and external memory signals of the hs32 memory arbiter.
interface hs32_mem_arbiter_if;
    logic [31:0] addr_f;
    logic [31:0] dtr_f;
    logic        reqm_f;
    logic        ackm_f;
    logic        flush;
    logic [31:0] addr_e;
    logic [31:0] dtw_e;
    logic [31:0] dtr_e;
    logic        rw_e;
    logic        reqm_e;
    logic        ackm_e;
    logic        fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_dtw;
    logic [31:0] mem_dtr;
    logic        mem_rw;
    logic        mem_stb;
    logic        mem_ack;
    modport slave (
        input  addr_f, reqm_f, flush, addr_e, dtw_e, rw_e, reqm_e, mem_dtr, mem_ack,
        output dtr_f, ackm_f, dtr_e, ackm_e, fault, mem_addr, mem_dtw, mem_rw, mem_stb
    );
    modport master (
        output addr_f, reqm_f, flush, addr_e, dtw_e, rw_e, reqm_e, mem_dtr, mem_ack,
        input  dtr_f, ackm_f, dtr_e, ackm_e, fault, mem_addr, mem_dtw, mem_rw, mem_stb
    );
endinterface

// File: rtl/hs32_mem_arbiter.sv
// hs32_mem_arbiter: single-transaction memory bus arbiter, execute priority with fetch starvation limit and timeout.
module hs32_mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input logic               clk,
    input logic               reset_n,
    hs32_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t      state;
    logic [3:0]  starve;
    logic [7:0]  tmo;
    logic        drop;
    logic        win_e;
    logic        grant_e;
    logic        grant_f;
    logic        timed_out;
    logic [31:0] rdata;
    always_comb begin
        grant_e   = bus.reqm_e && (starve < 4'(STARVE_MAX) || !bus.reqm_f || bus.flush);
        grant_f   = !grant_e && bus.reqm_f && !bus.flush;
        timed_out = !bus.mem_ack && tmo == 8'(TIMEOUT - 1);
        rdata     = (bus.mem_ack && !bus.mem_rw) ? bus.mem_dtr : '0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            starve       <= '0;
            tmo          <= '0;
            drop         <= 1'b0;
            win_e        <= 1'b0;
            bus.dtr_f    <= '0;
            bus.ackm_f   <= 1'b0;
            bus.dtr_e    <= '0;
            bus.ackm_e   <= 1'b0;
            bus.fault    <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_dtw  <= '0;
            bus.mem_rw   <= 1'b0;
            bus.mem_stb  <= 1'b0;
        end else begin
            bus.ackm_f <= 1'b0;
            bus.ackm_e <= 1'b0;
            case (state)
                IDLE: if (grant_e || grant_f) begin
                    state        <= BUSY;
                    bus.mem_stb  <= 1'b1;
                    tmo          <= '0;
                    win_e        <= grant_e;
                    bus.mem_addr <= grant_e ? bus.addr_e : bus.addr_f;
                    bus.mem_dtw  <= grant_e ? bus.dtw_e : '0;
                    bus.mem_rw   <= grant_e && bus.rw_e;
                    // a grant to execute only counts against fetch when fetch was actually eligible
                    starve       <= grant_f ? 4'd0 : starve + 4'(bus.reqm_f && !bus.flush);
                end
                BUSY: begin
                    if (!win_e && bus.flush) drop <= 1'b1;
                    if (bus.mem_ack || timed_out) begin
                        state       <= RESP;
                        bus.mem_stb <= 1'b0;
                        bus.fault   <= timed_out;
                        if (win_e) begin
                            bus.ackm_e <= 1'b1;
                            bus.dtr_e  <= rdata;
                        end else if (!(drop || bus.flush)) begin
                            bus.ackm_f <= 1'b1;
                            bus.dtr_f  <= rdata;
                        end
                    end else begin
                        tmo <= tmo + 8'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    drop      <= 1'b0;
                    bus.fault <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
